// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared constants for the M-extension unit: MULctr codes (also used by the decoder),
// FSM encoding, iteration latencies and operand helpers.
package ysyx_22050854_mdu_pkg;

  localparam logic [3:0] MDU_MUL    = 4'b0000;
  localparam logic [3:0] MDU_MULH   = 4'b0001;
  localparam logic [3:0] MDU_MULHSU = 4'b0010;
  localparam logic [3:0] MDU_MULHU  = 4'b0011;
  localparam logic [3:0] MDU_DIV    = 4'b0100;
  localparam logic [3:0] MDU_DIVU   = 4'b0101;
  localparam logic [3:0] MDU_REM    = 4'b0110;
  localparam logic [3:0] MDU_REMU   = 4'b0111;
  localparam logic [3:0] MDU_MULW   = 4'b1000;
  localparam logic [3:0] MDU_DIVW   = 4'b1100;
  localparam logic [3:0] MDU_DIVUW  = 4'b1101;
  localparam logic [3:0] MDU_REMW   = 4'b1110;
  localparam logic [3:0] MDU_REMUW  = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] LAT_D = 7'd64;
  localparam logic [6:0] LAT_W = 7'd32;

  typedef struct packed {
    logic valid;
    logic is_div;
    logic is_rem;
    logic s1;
    logic s2;
    logic word;
    logic high;
  } mdu_op_t;

  function automatic mdu_op_t decode_op(input logic [3:0] ctr);
    mdu_op_t op;
    op = '0;
    case (ctr)
      MDU_MUL:    begin op.valid = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; end
      MDU_MULH:   begin op.valid = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; op.high = 1'b1; end
      MDU_MULHSU: begin op.valid = 1'b1; op.s1 = 1'b1; op.high = 1'b1; end
      MDU_MULHU:  begin op.valid = 1'b1; op.high = 1'b1; end
      MDU_DIV:    begin op.valid = 1'b1; op.is_div = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; end
      MDU_DIVU:   begin op.valid = 1'b1; op.is_div = 1'b1; end
      MDU_REM:    begin op.valid = 1'b1; op.is_div = 1'b1; op.is_rem = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; end
      MDU_REMU:   begin op.valid = 1'b1; op.is_div = 1'b1; op.is_rem = 1'b1; end
      MDU_MULW:   begin op.valid = 1'b1; op.word = 1'b1; end
      MDU_DIVW:   begin op.valid = 1'b1; op.is_div = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; op.word = 1'b1; end
      MDU_DIVUW:  begin op.valid = 1'b1; op.is_div = 1'b1; op.word = 1'b1; end
      MDU_REMW:   begin op.valid = 1'b1; op.is_div = 1'b1; op.is_rem = 1'b1; op.s1 = 1'b1; op.s2 = 1'b1; op.word = 1'b1; end
      MDU_REMUW:  begin op.valid = 1'b1; op.is_div = 1'b1; op.is_rem = 1'b1; op.word = 1'b1; end
      default:    op = '0;
    endcase
    return op;
  endfunction

  // W ops look only at bits [31:0], extended according to the operand's signedness.
  function automatic logic [63:0] ext_op(input logic [63:0] v, input logic word, input logic sgn);
    return word ? {{32{sgn & v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050854_div_iter.sv
// Radix-2 restoring divider on operand magnitudes with sign correction and
// zero-latency handling of divide-by-zero and 64-bit signed overflow.
module ysyx_22050854_div_iter
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        sgn,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        done
);

  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg, div_zero, overflow;

  logic        active, special, neg_q, neg_r;
  logic [6:0]  cnt;
  logic [63:0] q, r, d;
  logic [64:0] rs, diff;

  always_comb begin
    a_ext    = ext_op(src1, word, sgn);
    b_ext    = ext_op(src2, word, sgn);
    a_neg    = sgn & a_ext[63];
    b_neg    = sgn & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == 64'd0);
    // W overflow (-2^31 / -1) comes out right from the magnitude path, so only
    // the 64-bit case short-circuits.
    overflow = sgn & ~word & (a_ext == 64'h8000_0000_0000_0000) & (b_ext == '1);
  end

  always_comb begin
    rs   = {r, q[63]};
    diff = rs - {1'b0, d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      special <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= 7'd0;
      q       <= 64'd0;
      r       <= 64'd0;
      d       <= 64'd0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= 7'd0;
    end else if (start) begin
      active  <= 1'b1;
      special <= div_zero | overflow;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      d       <= b_mag;
      if (div_zero) begin
        q   <= '1;
        r   <= a_ext;
        cnt <= 7'd0;
      end else if (overflow) begin
        q   <= a_ext;
        r   <= 64'd0;
        cnt <= 7'd0;
      end else begin
        // Dividend sits left-aligned so quotient bits shift in from the bottom.
        q   <= word ? {a_mag[31:0], 32'd0} : a_mag;
        r   <= 64'd0;
        cnt <= word ? LAT_W : LAT_D;
      end
    end else if (active) begin
      if (cnt == 7'd0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 7'd1;
        if (!diff[64]) begin
          r <= diff[63:0];
          q <= {q[62:0], 1'b1};
        end else begin
          r <= rs[63:0];
          q <= {q[62:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    done      = active & (cnt == 7'd0);
    quotient  = (special | ~neg_q) ? q : -q;
    remainder = (special | ~neg_r) ? r : -r;
  end

endmodule

// File: rtl/ysyx_22050854_mdu.sv
// RV64M multiply/divide unit: IDLE/BUSY/DONE FSM, iterative shift-add multiplier
// (single-cycle when YSYX_22050854_MDU_FAST_MUL_EN is defined) and restoring divider.
module ysyx_22050854_mdu
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  mul_ctr,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: an op transfers on a rising edge where in_valid & in_ready (IDLE
  // only) and flush is low; a result transfers where out_valid & out_ready, and
  // out_valid/result stay constant until then. flush beats both.

  logic [1:0]   state;
  logic [6:0]   cnt;
  logic         op_valid, op_div, op_rem, op_word, op_high, neg_p;
  logic [127:0] mcand, prod, prod_raw, prod_signed;
  logic [63:0]  mplier;

  mdu_op_t      dec;
  logic         accept;
  logic [63:0]  a_ext, b_ext, a_mag, b_mag;
  logic         a_neg, b_neg;
  logic [6:0]   mul_lat;

  logic [63:0]  quotient, remainder, div_sel, div_res, mul_res;
  logic         div_done;

  always_comb begin
    dec      = decode_op(mul_ctr);
    in_ready = (state == ST_IDLE);
    accept   = in_valid & in_ready & ~flush;
    a_ext    = ext_op(src1, dec.word, dec.s1);
    b_ext    = ext_op(src2, dec.word, dec.s2);
    a_neg    = dec.s1 & a_ext[63];
    b_neg    = dec.s2 & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
`ifdef YSYX_22050854_MDU_FAST_MUL_EN
    mul_lat  = 7'd0;
`else
    mul_lat  = dec.word ? LAT_W : LAT_D;
`endif
  end

  ysyx_22050854_div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & dec.valid & dec.is_div),
    .abort     (flush),
    .sgn       (dec.s1),
    .word      (dec.word),
    .src1      (src1),
    .src2      (src2),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (div_done)
  );

  always_comb begin
`ifdef YSYX_22050854_MDU_FAST_MUL_EN
    prod_raw = {64'd0, mcand[63:0]} * {64'd0, mplier};
`else
    prod_raw = prod;
`endif
    prod_signed = neg_p ? -prod_raw : prod_raw;
    if (!op_valid)    mul_res = 64'd0;
    else if (op_word) mul_res = sext_w(prod_signed[31:0]);
    else if (op_high) mul_res = prod_signed[127:64];
    else              mul_res = prod_signed[63:0];
    div_sel = op_rem ? remainder : quotient;
    div_res = op_word ? sext_w(div_sel[31:0]) : div_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 7'd0;
      op_valid <= 1'b0;
      op_div   <= 1'b0;
      op_rem   <= 1'b0;
      op_word  <= 1'b0;
      op_high  <= 1'b0;
      neg_p    <= 1'b0;
      mcand    <= 128'd0;
      mplier   <= 64'd0;
      prod     <= 128'd0;
      result   <= 64'd0;
    end else if (flush) begin
      state  <= ST_IDLE;
      cnt    <= 7'd0;
      result <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            op_valid <= dec.valid;
            op_div   <= dec.valid & dec.is_div;
            op_rem   <= dec.is_rem;
            op_word  <= dec.word;
            op_high  <= dec.high;
            neg_p    <= a_neg ^ b_neg;
            mcand    <= {64'd0, a_mag};
            mplier   <= b_mag;
            prod     <= 128'd0;
            cnt      <= (dec.valid & ~dec.is_div) ? mul_lat : 7'd0;
          end
        end
        ST_BUSY: begin
          if (op_div) begin
            if (div_done) begin
              result <= div_res;
              state  <= ST_DONE;
            end
          end else if (cnt == 7'd0) begin
            result <= mul_res;
            state  <= ST_DONE;
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 7'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_ysyx_22050854_mdu.sv
// Directed testbench for ysyx_22050854_mdu: driver tasks push expected result and
// arrival cycle; a negedge monitor checks every result the unit presents.
module tb_ysyx_22050854_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  mul_ctr = 4'd0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  logic [1:0]  dbg_state;

`ifdef YSYX_22050854_MDU_FAST_MUL_EN
  localparam int ML = 0;
  localparam int MW = 0;
`else
  localparam int ML = 64;
  localparam int MW = 32;
`endif

  ysyx_22050854_mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_ctr   (mul_ctr),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  logic        prev_ov = 1'b0;
  logic [63:0] cur_exp = 64'd0;
  string       cur_name = "none";
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result %h with nothing expected", result);
      end else begin
        cur_exp  = exp_q.pop_front();
        cur_name = name_q.pop_front();
        check64(cur_name, result, cur_exp);
        check_int({cur_name, "_cycle"}, cyc, cyc_q.pop_front());
      end
    end else if (out_valid) begin
      check64({cur_name, "_hold"}, result, cur_exp);
    end
    prev_ov = out_valid;
  end

  // driver: lat is the expected iteration count; out_valid arrives lat+1 edges after accept
  task automatic issue(input logic [3:0] ctr, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input string nm, input int hold);
    int t;
    @(negedge clk);
    check_int({nm, "_in_ready"}, int'(in_ready), 1);
    mul_ctr   = ctr;
    src1      = a;
    src2      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + lat + 1);
    name_q.push_back(nm);
    in_valid = 1'b0;
    mul_ctr  = 4'($urandom_range(0, 15));
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 200);
    check_int({nm, "_valid_seen"}, int'(out_valid), 1);
    check_int({nm, "_no_ready_in_done"}, int'(in_ready), 0);
    repeat (hold) begin
      @(negedge clk);
      check_int({nm, "_valid_held"}, int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_int({nm, "_idle_after"}, int'(busy), 0);
  endtask

  task automatic expect_idle(input string nm);
    check_int({nm, "_busy"}, int'(busy), 0);
    check_int({nm, "_out_valid"}, int'(out_valid), 0);
    check_int({nm, "_in_ready"}, int'(in_ready), 1);
    check_int({nm, "_state"}, int'(dbg_state), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("reset");
    check64("reset_result", result, 64'd0);

    issue(4'b0000, 64'h7, 64'h6, 64'h2A, ML, "mul_7x6", 0);
    issue(4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, ML, "mulh_m1x2", 0);
    issue(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, ML, "mulhu_max_x2", 0);
    issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, ML, "mulhsu_m1x2", 0);
    issue(4'b0010, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ML, "mulhsu_2xmax", 0);
    issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 64'hFFFF_FFFF_FFFF_FFF1, ML, "mul_m3x5", 0);
    issue(4'b1000, 64'hABCD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, MW, "mulw", 0);
    issue(4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div_m7_2", 0);
    issue(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "rem_m7_2", 0);
    issue(4'b0100, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div_7_m2", 0);
    issue(4'b0110, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64, "rem_7_m2", 0);
    issue(4'b0101, 64'd100, 64'd7, 64'd14, 64, "divu_100_7", 0);
    issue(4'b0111, 64'd100, 64'd7, 64'd2, 64, "remu_100_7", 0);
    issue(4'b0101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu_by_zero", 0);
    issue(4'b0110, 64'd5, 64'd0, 64'd5, 0, "rem_by_zero", 0);
    issue(4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, "div_overflow", 0);
    issue(4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, "rem_overflow", 0);
    issue(4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 32, "divw_min_m1", 0);
    issue(4'b1100, 64'd20, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 32, "divw_20_m3", 0);
    issue(4'b1110, 64'd20, 64'hFFFF_FFFD, 64'h2, 32, "remw_20_m3", 0);
    issue(4'b1101, 64'h5555_0000_FFFF_FFFF, 64'h2, 64'h7FFF_FFFF, 32, "divuw", 0);
    issue(4'b1111, 64'h8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 0, "remuw_by_zero", 0);
    issue(4'b1100, 64'h12, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divw_by_zero", 0);
    issue(4'b1001, 64'h7, 64'h6, 64'h0, 0, "unsupported", 0);
    issue(4'b0000, 64'h1_2345_6789, 64'h10, 64'h12_3456_7890, ML, "mul_hold", 5);

    // flush at BUSY cycle 10
    @(negedge clk);
    mul_ctr  = 4'b0100;
    src1     = 64'd1000;
    src2     = 64'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_int("flush_busy_before", int'(busy), 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    expect_idle("flush_busy");
    repeat (80) @(negedge clk);
    check_int("flush_no_result", int'(out_valid), 0);

    // flush together with in_valid in IDLE accepts nothing
    @(negedge clk);
    mul_ctr  = 4'b0000;
    src1     = 64'd3;
    src2     = 64'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    expect_idle("flush_idle");
    repeat (70) @(negedge clk);
    check_int("flush_idle_no_result", int'(out_valid), 0);

    // reset in the middle of a divide
    @(negedge clk);
    mul_ctr  = 4'b0101;
    src1     = 64'd77;
    src2     = 64'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_idle("reset_mid");
    check64("reset_mid_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check_int("reset_mid_no_result", int'(out_valid), 0);

    issue(4'b0000, 64'd9, 64'd9, 64'd81, ML, "mul_after_reset", 0);

    repeat (3) @(negedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_mdu.md
YSYX_22050854_MDU -- requirements
Module: ysyx_22050854_MDU

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1  decoded M-op present.
REQ-004 SHALL have: in_ready  out  1  unit can accept; high only in IDLE.
REQ-005 SHALL have: mul_ctr  in  4  decoder MULctr code: 0000 mul, 0001 mulh, 0010 mulhsu, 0011 mulhu, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw; others unsupported.
REQ-006 SHALL have: src1, src2  in  64  rs1/rs2 operands.
REQ-007 SHALL have: flush  in  1  abandon current op (pipeline redirect).
REQ-008 SHALL have: out_valid  out  1  result available.
REQ-009 SHALL have: out_ready  in  1  consumer takes result.
REQ-010 SHALL have: result  out  64  final result.
REQ-011 SHALL have: busy  out  1  high in BUSY or DONE.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE; accept = in_valid & in_ready in IDLE.
REQ-013 SHALL latch mul_ctr, src1, src2 on accept; inputs ignored otherwise.
REQ-014 SHALL iterate L cycles in BUSY then enter DONE: L=64 for 64-bit ops, L=32 for W ops; out_valid first high L+1 edges after accepting edge.
REQ-015 SHALL compute mul via radix-2 shift-add over 128-bit product; mul low 64, mulh/mulhsu/mulhu high 64 with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-016 SHALL compute div/rem via radix-2 restoring division on magnitudes, sign-correcting quotient (sign1^sign2) and remainder (sign of dividend).
REQ-017 SHALL, for W ops, use src[31:0] (sign- or zero-extended per op) and sign-extend the 32-bit result to 64.
REQ-018 SHALL handle divide-by-zero with L=0: quotient all ones (W: 0xFFFFFFFF sign-extended), remainder = dividend.
REQ-019 SHALL handle signed overflow (min / -1) with L=0: quotient = dividend, remainder 0.
REQ-020 SHALL accept unsupported mul_ctr codes with L=0 and result 0.
REQ-021 SHALL hold out_valid and result stable in DONE until out_ready; DONE->IDLE on out_valid & out_ready.
REQ-022 SHALL NOT accept a new op in the cycle a result is consumed (in_ready low in DONE).
REQ-023 SHALL, on flush in any state, return to IDLE next edge, drop result, out_valid low; flush with in_valid in IDLE accepts nothing.

Reset
REQ-024 SHALL, on rst_n low, asynchronously enter IDLE, clear iteration counter and datapath registers; out_valid=0, result=0, busy=0, in_ready=1 after release.
REQ-025 SHALL abort any in-flight op on reset mid-operation with no result emitted.

Configuration
REQ-026 SHALL, with YSYX_22050854_MDU_FAST_MUL_EN defined, compute all multiply ops with a single-cycle combinational multiplier (L=0, out_valid one edge after accept).
REQ-027 SHALL, without YSYX_22050854_MDU_FAST_MUL_EN, use the iterative multiplier of REQ-015; divide latency unaffected either way.

Structure
REQ-028 SHALL place mul_ctr code constants, state encoding, and latency constants (64, 32) in shared package ysyx_22050854_mdu_pkg, also used by the decoder.
REQ-029 SHALL factor the restoring divider into sub-module ysyx_22050854_div_iter (start, signedness, word flag, operands -> quotient, remainder, done).

Verification
REQ-030 SHALL check mul 0x7 * 0x6 -> result 0x2A, out_valid 65 edges after accept (1 with FAST_MUL_EN).
REQ-031 SHALL check mulh 0xFFFFFFFFFFFFFFFF * 0x2 -> 0xFFFFFFFFFFFFFFFF; mulhu same operands -> 0x1.
REQ-032 SHALL check div -7/2 -> 0xFFFFFFFFFFFFFFFD, rem -7/2 -> 0xFFFFFFFFFFFFFFFF, latency 65.
REQ-033 SHALL check divu 5/0 -> 0xFFFFFFFFFFFFFFFF and div 0x8000000000000000/-1 -> 0x8000000000000000, each out_valid one edge after accept.
REQ-034 SHALL check divw src1=0x80000000, src2=0xFFFFFFFF -> 0xFFFFFFFF80000000, latency 33.
REQ-035 SHALL check flush at BUSY cycle 10 -> IDLE next edge, no out_valid; out_ready held low 5 cycles in DONE -> result stable throughout.
